// File: rtl/fft_mag_peak.sv
// Magnitude-squared stream of fft_core output bins, tagged with bin index,
// plus a once-per-frame report of the largest bin.
module fft_mag_peak #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned FRAME_LEN = 128,
   parameter int unsigned BIN_W     = 7
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [2*DATA_W-1:0]   s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [2*DATA_W-1:0]   m_axis_tdata,
   output logic [BIN_W-1:0]      m_axis_tuser,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  peak_valid,
   output logic [BIN_W-1:0]      peak_bin,
   output logic [2*DATA_W-1:0]   peak_mag,
   output logic                  event_tlast_unexpected,
   output logic                  event_tlast_missing
);

   localparam int unsigned      PW       = 2 * DATA_W;
   localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FRAME_LEN - 1);

   // Bin counter and event pulses
   logic [BIN_W-1:0]     bin_q, bin_d;
   logic                 ev_unx_q, ev_unx_d;
   logic                 ev_mis_q, ev_mis_d;

   // Stage 1: squared components
   logic                 v1_q, v1_d;
   logic signed [PW-1:0] pre_q, pre_d;
   logic signed [PW-1:0] pim_q, pim_d;
   logic [BIN_W-1:0]     bin1_q, bin1_d;
   logic                 last1_q, last1_d;
   logic                 first1_q, first1_d;

   // Stage 2: output beat
   logic                 mv_q, mv_d;
   logic [PW-1:0]        mdata_q, mdata_d;
   logic [BIN_W-1:0]     muser_q, muser_d;
   logic                 mlast_q, mlast_d;

   // Running and reported peak
   logic [PW-1:0]        rmag_q, rmag_d;
   logic [BIN_W-1:0]     rbin_q, rbin_d;
   logic                 pkv_q, pkv_d;
   logic [BIN_W-1:0]     pkbin_q, pkbin_d;
   logic [PW-1:0]        pkmag_q, pkmag_d;

   logic                 ce;
   logic                 accept;
   logic                 at_last_bin;
   logic                 frame_end;
   logic signed [DATA_W-1:0] re_c, im_c;
   logic signed [PW-1:0]     re_ext, im_ext;
   logic [PW-1:0]            mag_c;

   assign ce            = !mv_q || m_axis_tready;
   assign s_axis_tready = ce && !areset;
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign at_last_bin   = (bin_q == LAST_BIN);
   assign frame_end     = s_axis_tlast || at_last_bin;

   assign re_c   = s_axis_tdata[DATA_W-1:0];
   assign im_c   = s_axis_tdata[PW-1:DATA_W];
   assign re_ext = PW'(re_c);
   assign im_ext = PW'(im_c);
   // Each square is non-negative and at most 2^(PW-2), so the sum cannot overflow
   assign mag_c  = $unsigned(pre_q) + $unsigned(pim_q);

   // Next-state logic
   always_comb begin
      bin_d    = bin_q;
      ev_unx_d = 1'b0;
      ev_mis_d = 1'b0;
      v1_d     = v1_q;
      pre_d    = pre_q;
      pim_d    = pim_q;
      bin1_d   = bin1_q;
      last1_d  = last1_q;
      first1_d = first1_q;
      mv_d     = mv_q;
      mdata_d  = mdata_q;
      muser_d  = muser_q;
      mlast_d  = mlast_q;
      rmag_d   = rmag_q;
      rbin_d   = rbin_q;
      pkv_d    = 1'b0;
      pkbin_d  = pkbin_q;
      pkmag_d  = pkmag_q;

      if (accept) begin
         bin_d    = frame_end ? '0 : bin_q + BIN_W'(1);
         ev_unx_d = s_axis_tlast && !at_last_bin;
         ev_mis_d = at_last_bin && !s_axis_tlast;
      end

      if (ce) begin
         v1_d     = accept;
         pre_d    = re_ext * re_ext;
         pim_d    = im_ext * im_ext;
         bin1_d   = bin_q;
         last1_d  = frame_end;
         first1_d = (bin_q == '0);
         mv_d     = v1_q;
         mdata_d  = mag_c;
         muser_d  = bin1_q;
         mlast_d  = last1_q;
         // Strict compare keeps the lowest bin on ties
         if (v1_q && (first1_q || (mag_c > rmag_q))) begin
            rmag_d = mag_c;
            rbin_d = bin1_q;
         end
      end

      // Report once the frame-end beat has been taken downstream
      if (mv_q && m_axis_tready && mlast_q) begin
         pkv_d   = 1'b1;
         pkbin_d = rbin_q;
         pkmag_d = rmag_q;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         bin_q    <= '0;
         ev_unx_q <= 1'b0;
         ev_mis_q <= 1'b0;
         v1_q     <= 1'b0;
         pre_q    <= '0;
         pim_q    <= '0;
         bin1_q   <= '0;
         last1_q  <= 1'b0;
         first1_q <= 1'b0;
         mv_q     <= 1'b0;
         mdata_q  <= '0;
         muser_q  <= '0;
         mlast_q  <= 1'b0;
         rmag_q   <= '0;
         rbin_q   <= '0;
         pkv_q    <= 1'b0;
         pkbin_q  <= '0;
         pkmag_q  <= '0;
      end else begin
         bin_q    <= bin_d;
         ev_unx_q <= ev_unx_d;
         ev_mis_q <= ev_mis_d;
         v1_q     <= v1_d;
         pre_q    <= pre_d;
         pim_q    <= pim_d;
         bin1_q   <= bin1_d;
         last1_q  <= last1_d;
         first1_q <= first1_d;
         mv_q     <= mv_d;
         mdata_q  <= mdata_d;
         muser_q  <= muser_d;
         mlast_q  <= mlast_d;
         rmag_q   <= rmag_d;
         rbin_q   <= rbin_d;
         pkv_q    <= pkv_d;
         pkbin_q  <= pkbin_d;
         pkmag_q  <= pkmag_d;
      end
   end

   assign m_axis_tdata           = mdata_q;
   assign m_axis_tuser           = muser_q;
   assign m_axis_tlast           = mlast_q;
   assign m_axis_tvalid          = mv_q;
   assign peak_valid             = pkv_q;
   assign peak_bin               = pkbin_q;
   assign peak_mag               = pkmag_q;
   assign event_tlast_unexpected = ev_unx_q;
   assign event_tlast_missing    = ev_mis_q;

endmodule

// File: tb/tb_fft_mag_peak.sv
// Directed bench for fft_mag_peak with FRAME_LEN=8.
module tb_fft_mag_peak;

   localparam int unsigned DW = 16;
   localparam int unsigned FL = 8;
   localparam int unsigned BW = 3;

   logic          clk = 1'b0;
   logic          areset = 1'b1;
   logic [31:0]   s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic          s_tlast = 1'b0;
   logic [31:0]   m_tdata;
   logic [BW-1:0] m_tuser;
   logic          m_tlast;
   logic          m_tvalid;
   logic          m_tready = 1'b1;
   logic          pk_valid;
   logic [BW-1:0] pk_bin;
   logic [31:0]   pk_mag;
   logic          ev_unx;
   logic          ev_mis;

   fft_mag_peak #(.DATA_W(DW), .FRAME_LEN(FL), .BIN_W(BW)) dut (
      .aclk                   (clk),
      .areset                 (areset),
      .s_axis_tdata           (s_tdata),
      .s_axis_tvalid          (s_tvalid),
      .s_axis_tready          (s_tready),
      .s_axis_tlast           (s_tlast),
      .m_axis_tdata           (m_tdata),
      .m_axis_tuser           (m_tuser),
      .m_axis_tlast           (m_tlast),
      .m_axis_tvalid          (m_tvalid),
      .m_axis_tready          (m_tready),
      .peak_valid             (pk_valid),
      .peak_bin               (pk_bin),
      .peak_mag               (pk_mag),
      .event_tlast_unexpected (ev_unx),
      .event_tlast_missing    (ev_mis)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // Observed output handshakes, peak reports and event pulses
   logic [31:0]   od[$];
   logic [BW-1:0] ou[$];
   logic          ol[$];
   int            oc[$];
   logic [BW-1:0] pb[$];
   logic [31:0]   pm[$];
   int            ic[$];
   int            n_unx = 0;
   int            n_mis = 0;

   always @(negedge clk) begin
      if (!areset) begin
         if (m_tvalid && m_tready) begin
            od.push_back(m_tdata);
            ou.push_back(m_tuser);
            ol.push_back(m_tlast);
            oc.push_back(cyc + 1);
         end
         if (pk_valid) begin
            pb.push_back(pk_bin);
            pm.push_back(pk_mag);
         end
         if (ev_unx) n_unx = n_unx + 1;
         if (ev_mis) n_mis = n_mis + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests = n_tests + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one beat and hold it until accepted; returns at posedge+1
   task automatic send(input int re, input int im, input bit last);
      int guard = 0;
      s_tdata  = {16'(im), 16'(re)};
      s_tvalid = 1'b1;
      s_tlast  = last;
      @(negedge clk);
      while (!s_tready && guard < 100) begin
         guard = guard + 1;
         @(negedge clk);
      end
      if (guard >= 100) check("send_timeout", 64'(guard), 64'd0);
      ic.push_back(cyc + 1);
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain();
      repeat (6) @(posedge clk);
      #1;
   endtask

   int t2re[8] = '{-32768, 32767, 0, 0, 0, 0, 0, 0};
   int t2im[8] = '{-32768, 0, 0, 0, 0, 0, 0, 0};
   int t3a[8]  = '{1, 2, 3, 10, 10, 9, 0, 0};
   int t3b[8]  = '{1, 2, 3, 10, 10, 9, 20, 0};
   int t5a[5]  = '{1, 2, 7, 3, 4};

   initial begin
      int b, pk, a, u0, m0;

      // Reset state
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_tready", 64'(s_tready), 64'd0);
      check("rst_mvalid", 64'(m_tvalid), 64'd0);
      check("rst_peak_valid", 64'(pk_valid), 64'd0);
      check("rst_peak_mag", 64'(pk_mag), 64'd0);
      @(posedge clk);
      #1 areset = 1'b0;
      @(negedge clk);
      check("post_rst_tready", 64'(s_tready), 64'd1);
      @(posedge clk);
      #1;

      // Constant 3+4j frame
      b = od.size(); pk = pb.size(); a = ic.size();
      for (int i = 0; i < 8; i++) send(3, 4, i == 7);
      drain();
      check("t1_count", 64'(od.size() - b), 64'd8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t1_mag%0d", i), 64'(od[b+i]), 64'd25);
         check($sformatf("t1_bin%0d", i), 64'(ou[b+i]), 64'(i));
         check($sformatf("t1_last%0d", i), 64'(ol[b+i]), 64'(i == 7));
      end
      check("t1_latency", 64'(oc[b] - ic[a]), 64'd2);
      check("t1_peak_count", 64'(pb.size() - pk), 64'd1);
      check("t1_peak_bin", 64'(pb[pk]), 64'd0);
      check("t1_peak_mag", 64'(pm[pk]), 64'd25);

      // Extreme operands
      b = od.size(); pk = pb.size();
      for (int i = 0; i < 8; i++) send(t2re[i], t2im[i], i == 7);
      drain();
      check("t2_min_min", 64'(od[b]), 64'h8000_0000);
      check("t2_max_re", 64'(od[b+1]), 64'h3FFF_0001);
      check("t2_peak_bin", 64'(pb[pk]), 64'd0);
      check("t2_peak_mag", 64'(pm[pk]), 64'h8000_0000);

      // Tie handling, then back-to-back frame with a new peak
      b = od.size(); pk = pb.size();
      for (int i = 0; i < 8; i++) send(t3a[i], 0, i == 7);
      for (int i = 0; i < 8; i++) send(t3b[i], 0, i == 7);
      drain();
      check("t3_count", 64'(od.size() - b), 64'd16);
      check("t3_mag3", 64'(od[b+3]), 64'd100);
      check("t3_mag4", 64'(od[b+4]), 64'd100);
      check("t3_peak_count", 64'(pb.size() - pk), 64'd2);
      check("t3a_peak_bin", 64'(pb[pk]), 64'd3);
      check("t3a_peak_mag", 64'(pm[pk]), 64'd100);
      check("t3b_peak_bin", 64'(pb[pk+1]), 64'd6);
      check("t3b_peak_mag", 64'(pm[pk+1]), 64'd400);

      // Downstream stall of 5 cycles mid-frame
      b = od.size(); pk = pb.size();
      fork
         begin
            for (int i = 0; i < 8; i++) send(i + 1, 0, i == 7);
         end
         begin
            repeat (4) @(posedge clk);
            #1 m_tready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check($sformatf("t4_stall_tready%0d", k), 64'(s_tready), 64'd0);
               check($sformatf("t4_stall_mvalid%0d", k), 64'(m_tvalid), 64'd1);
               check($sformatf("t4_stall_data%0d", k), 64'(m_tdata), 64'd9);
               check($sformatf("t4_stall_bin%0d", k), 64'(m_tuser), 64'd2);
            end
            @(posedge clk);
            #1 m_tready = 1'b1;
         end
      join
      drain();
      check("t4_count", 64'(od.size() - b), 64'd8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t4_mag%0d", i), 64'(od[b+i]), 64'((i + 1) * (i + 1)));
         check($sformatf("t4_bin%0d", i), 64'(ou[b+i]), 64'(i));
      end
      check("t4_peak_bin", 64'(pb[pk]), 64'd7);
      check("t4_peak_mag", 64'(pm[pk]), 64'd64);

      // Early tlast at bin 4
      b = od.size(); pk = pb.size(); u0 = n_unx; m0 = n_mis;
      for (int i = 0; i < 5; i++) send(t5a[i], 0, i == 4);
      drain();
      check("t5a_count", 64'(od.size() - b), 64'd5);
      check("t5a_last3", 64'(ol[b+3]), 64'd0);
      check("t5a_last4", 64'(ol[b+4]), 64'd1);
      check("t5a_unexpected", 64'(n_unx - u0), 64'd1);
      check("t5a_missing", 64'(n_mis - m0), 64'd0);
      check("t5a_peak_bin", 64'(pb[pk]), 64'd2);
      check("t5a_peak_mag", 64'(pm[pk]), 64'd49);

      // Full frame without tlast
      b = od.size(); pk = pb.size();
      for (int i = 0; i < 8; i++) send(1, 0, 1'b0);
      drain();
      check("t5b_count", 64'(od.size() - b), 64'd8);
      check("t5b_first_bin", 64'(ou[b]), 64'd0);
      check("t5b_last6", 64'(ol[b+6]), 64'd0);
      check("t5b_last7", 64'(ol[b+7]), 64'd1);
      check("t5b_missing", 64'(n_mis - m0), 64'd1);
      check("t5b_unexpected", 64'(n_unx - u0), 64'd1);
      check("t5b_peak_bin", 64'(pb[pk]), 64'd0);
      check("t5b_peak_mag", 64'(pm[pk]), 64'd1);

      // Reset with beats in flight
      b = od.size(); pk = pb.size(); u0 = n_unx; m0 = n_mis;
      for (int i = 0; i < 4; i++) send(1, 0, 1'b0);
      areset = 1'b1;
      @(posedge clk);
      #1 areset = 1'b0;
      @(negedge clk);
      check("t6_mvalid_cleared", 64'(m_tvalid), 64'd0);
      check("t6_tready", 64'(s_tready), 64'd1);
      drain();
      check("t6_pre_count", 64'(od.size() - b), 64'd2);
      check("t6_no_peak", 64'(pb.size() - pk), 64'd0);
      b = od.size();
      for (int i = 0; i < 8; i++) send(2, 0, i == 7);
      drain();
      check("t6_count", 64'(od.size() - b), 64'd8);
      check("t6_first_bin", 64'(ou[b]), 64'd0);
      check("t6_last7", 64'(ol[b+7]), 64'd1);
      check("t6_peak_count", 64'(pb.size() - pk), 64'd1);
      check("t6_peak_bin", 64'(pb[pk]), 64'd0);
      check("t6_peak_mag", 64'(pm[pk]), 64'd4);
      check("t6_events", 64'((n_unx - u0) + (n_mis - m0)), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fft_mag_peak.md
Name: fft_mag_peak

Overview:
- Consumes the complex output stream of fft_core (AXI-Stream, {imag[31:16], real[15:0]}, signed).
- Produces a per-bin magnitude-squared stream tagged with the bin index.
- Tracks the largest bin of each frame and reports it once per frame.
- Sits directly downstream of fft_core; its slave port connects to fft_core m_axis_data_*.

Parameters:
DATA_W, 16, width of each signed real/imag component
FRAME_LEN, 128, FFT points per frame (power of two, >=4)
BIN_W, 7, log2(FRAME_LEN); width of bin index

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous reset, active-high
s_axis_tdata  in  2*DATA_W  {imag, real}, two's complement
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input beat accepted when tvalid&tready
s_axis_tlast  in  1  last bin of frame
m_axis_tdata  out  2*DATA_W  unsigned re^2+im^2
m_axis_tuser  out  BIN_W  bin index of this beat
m_axis_tlast  out  1  last beat of frame
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  downstream ready
peak_valid  out  1  one-cycle pulse: peak_bin/peak_mag updated
peak_bin  out  BIN_W  bin of largest magnitude in last completed frame
peak_mag  out  2*DATA_W  that magnitude
event_tlast_unexpected  out  1  one-cycle pulse: tlast before bin FRAME_LEN-1
event_tlast_missing  out  1  one-cycle pulse: bin FRAME_LEN-1 without tlast

Behaviour:
- Reset: all outputs 0 on the cycle areset is sampled high; pipeline valids cleared, bin counter 0, running peak cleared. s_axis_tready is 0 during reset and 1 in the first cycle after reset. Reset mid-frame discards every in-flight beat; no peak_valid for the aborted frame.
- Pipeline, 2 stages. Stage 1 registers re*re and im*im as signed 2*DATA_W products. Stage 2 registers their unsigned sum. Sum width is 2*DATA_W with no overflow: maximum is 2*2^(2*DATA_W-2) = 2^(2*DATA_W-1).
- Clock enable ce = !m_axis_tvalid | m_axis_tready. s_axis_tready = ce. When ce=0 the whole pipeline holds and m_axis_* stay stable.
- Latency: a beat accepted at edge N appears on m_axis at edge N+2 when unstalled. Full throughput is 1 beat/cycle.
- Bin counter:
  - Increments on each accepted input beat; the beat carries the pre-increment value as its bin.
  - Frame end is accepted beat with s_axis_tlast=1, or bin==FRAME_LEN-1.
  - At frame end the counter returns to 0 and m_axis_tlast=1 on that beat.
  - tlast with bin<FRAME_LEN-1: pulse event_tlast_unexpected in the cycle after acceptance; frame ends early.
  - bin==FRAME_LEN-1 with tlast=0: pulse event_tlast_missing in the cycle after acceptance; frame ends anyway.
- Peak tracking:
  - Updated when a beat loads into stage 2 (ce=1). First beat of a frame always loads the running peak.
  - Later beats replace it only if mag > running peak (strict); ties keep the lowest bin.
  - When the frame-end beat completes its output handshake, peak_bin/peak_mag take the final result and peak_valid pulses high for the next cycle.
  - Running peak restarts with the next frame's first beat. Back-to-back frames need no gap.
- peak_bin/peak_mag hold until the next report.
- All internal arithmetic is signed-extended before multiply. Results are never truncated or saturated.

Test Plan:
- FRAME_LEN=8; 8 beats re=3, im=4, m_axis_tready=1 -> m_axis_tdata=25 for bins 0..7, each 2 cycles after input; tlast on bin 7 only; peak_valid once with peak_bin=0, peak_mag=25.
- Single beat re=-32768, im=-32768 -> m_axis_tdata=0x80000000. Beat re=32767, im=0 -> 0x3FFF0001.
- FRAME_LEN=8; re={1,2,3,10,10,9,0,0}, im=0 -> peak_bin=3, peak_mag=100 (tie at bin 4 ignored); second frame with bin 6 re=20 -> peak_bin=6, peak_mag=400.
- m_axis_tready low for 5 cycles mid-frame -> s_axis_tready low the same cycles, no beat lost or duplicated, m_axis_tdata stable while stalled, bin sequence contiguous.
- FRAME_LEN=8; tlast at bin 4 -> event_tlast_unexpected pulse, m_axis_tlast on bin 4, peak reported, next beat bin 0. 8 beats with no tlast -> event_tlast_missing pulse, m_axis_tlast on bin 7.
- areset high for 1 cycle at bin 3 with 2 beats in flight -> no further m_axis_tvalid or peak_valid from that frame; next frame starts at bin 0.
